// File: rtl/carry_skip_pkg.sv
// Shared constants, types and golden reference for the 8-bit carry-skip adder.
package carry_skip_pkg;

  localparam int unsigned ADD_W = 8;

  typedef logic [ADD_W-1:0] add_word_t;

  // Reference 9-bit sum {co, s}.
  function automatic logic [ADD_W:0] ref_add(input add_word_t a, input add_word_t b,
                                             input logic ci);
    return (ADD_W+1)'(a) + (ADD_W+1)'(b) + (ADD_W+1)'(ci);
  endfunction

endpackage

// File: rtl/carry_skip_block.sv
// One carry-skip block: W-bit ripple chain, block-propagate AND and skip mux.
module carry_skip_block #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  logic [W-1:0] p;
  logic         c;

  assign p = a ^ b;

  // Sum always comes from the ripple chain; the skip mux only shortcuts cout.
  always_comb begin
    c    = cin;
    s    = '0;
    cmsb = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      if (i == int'(W) - 1) cmsb = c;
      s[i] = p[i] ^ c;
      c    = (a[i] & b[i]) | (p[i] & c);
    end
    cout = (&p) ? cin : c;
  end

endmodule

// File: rtl/carry_skip_adder8.sv
// 8-bit carry-skip adder with registered sum/carry-out.
// Define CARRY_SKIP_OVF_EN to add a registered two's-complement overflow output ovf.
module carry_skip_adder8
  import carry_skip_pkg::*;
#(
  parameter int unsigned BLOCK_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             ci,
  output logic [ADD_W-1:0] s,
  output logic             co
`ifdef CARRY_SKIP_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NB = (BLOCK_W == 0) ? 1 : ADD_W / BLOCK_W;

  if (BLOCK_W == 0 || (ADD_W % BLOCK_W) != 0) begin : g_bad_block_w
    $error("carry_skip_adder8: BLOCK_W must divide 8");
  end

  logic [NB:0]      carry;
  logic [NB-1:0]    blk_cmsb;
  logic [ADD_W-1:0] sum_c;
  logic             unused_cmsb;

  assign carry[0]    = ci;
  assign unused_cmsb = ^blk_cmsb;

  // Block chain: each block's skip-mux output feeds the next block's carry-in.
  for (genvar k = 0; k < int'(NB); k++) begin : g_blk
    carry_skip_block #(.W(BLOCK_W)) u_blk (
      .a    (a[k*BLOCK_W +: BLOCK_W]),
      .b    (b[k*BLOCK_W +: BLOCK_W]),
      .cin  (carry[k]),
      .s    (sum_c[k*BLOCK_W +: BLOCK_W]),
      .cout (carry[k+1]),
      .cmsb (blk_cmsb[k])
    );
  end

  logic [ADD_W-1:0] s_d, s_q;
  logic             co_d, co_q;

  assign s_d  = sum_c;
  assign co_d = carry[NB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= co_d;
    end
  end

  assign s  = s_q;
  assign co = co_q;

`ifdef CARRY_SKIP_OVF_EN
  logic ovf_d, ovf_q;

  // Overflow: carry into bit 7 differs from carry out of bit 7.
  assign ovf_d = blk_cmsb[NB-1] ^ carry[NB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_carry_skip_adder8.sv
// Self-checking bench for carry_skip_adder8: directed table, back-to-back, reset cases, random.
module tb_carry_skip_adder8;
  import carry_skip_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       ci = 1'b0;
  logic [7:0] s;
  logic       co;
`ifdef CARRY_SKIP_OVF_EN
  logic       ovf;
`endif

  carry_skip_adder8 #(.BLOCK_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .ci  (ci),
    .s   (s),
    .co  (co)
`ifdef CARRY_SKIP_OVF_EN
    ,
    .ovf (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] es;
    logic       eco;
    logic       eovf;
  } vec_t;

  typedef struct {
    logic [7:0] es;
    logic       eco;
    logic       eovf;
    int         tag;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[14];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int tag, input logic [8:0] act,
                     input logic [8:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s #%0d actual=%0h required=%0h", name, tag, act, expv);
    end
  endtask

  // Pop the oldest expectation and compare against the registered outputs.
  task automatic check_pending();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sum", e.tag, {1'b0, s}, {1'b0, e.es});
      chk("carry_out", e.tag, {8'd0, co}, {8'd0, e.eco});
`ifdef CARRY_SKIP_OVF_EN
      chk("overflow", e.tag, {8'd0, ovf}, {8'd0, e.eovf});
`endif
    end
  endtask

  // At a falling edge: check the previous result, then drive new inputs and push expectation.
  task automatic drive(input logic [7:0] va, input logic [7:0] vb, input logic vci,
                       input logic [7:0] es, input logic eco, input logic eovf, input int tag);
    exp_t e;
    @(negedge clk);
    check_pending();
    a  = va;
    b  = vb;
    ci = vci;
    e.es = es; e.eco = eco; e.eovf = eovf; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic flush();
    @(negedge clk);
    check_pending();
  endtask

  function automatic logic sign_ovf(input logic [7:0] va, input logic [7:0] vb,
                                    input logic [7:0] vs);
    return (va[7] == vb[7]) && (vs[7] != va[7]);
  endfunction

  initial begin
    logic [8:0] r;
    logic [7:0] ra, rb;
    logic       rc;

    tbl[0]  = '{8'd5,   8'd10,  1'b1, 8'd16,  1'b0, 1'b0};
    tbl[1]  = '{8'd37,  8'd48,  1'b0, 8'd85,  1'b0, 1'b0};
    tbl[2]  = '{8'd125, 8'd110, 1'b1, 8'd236, 1'b0, 1'b1};
    tbl[3]  = '{8'd122, 8'd11,  1'b1, 8'd134, 1'b0, 1'b1};
    tbl[4]  = '{8'd245, 8'd2,   1'b0, 8'd247, 1'b0, 1'b0};
    tbl[5]  = '{8'd3,   8'd90,  1'b1, 8'd94,  1'b0, 1'b0};
    tbl[6]  = '{8'd63,  8'd211, 1'b0, 8'd18,  1'b1, 1'b0};
    tbl[7]  = '{8'd100, 8'd200, 1'b0, 8'd44,  1'b1, 1'b0};
    tbl[8]  = '{8'd127, 8'd127, 1'b1, 8'd255, 1'b0, 1'b1};
    tbl[9]  = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0};
    tbl[10] = '{8'hFF,  8'h00,  1'b1, 8'd0,   1'b1, 1'b0};
    tbl[11] = '{8'hF0,  8'h0F,  1'b0, 8'd255, 1'b0, 1'b0};
    tbl[12] = '{8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1};
    tbl[13] = '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1, 1'b1};

    // Reset held with live inputs while clocking.
    rst = 1'b1; a = 8'd127; b = 8'd127; ci = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_sum", 0, {1'b0, s}, 9'd0);
    chk("reset_co", 0, {8'd0, co}, 9'd0);
    rst = 1'b0;

    // First capture after release, then the directed table back-to-back.
    for (int i = 0; i < 14; i++)
      drive(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].es, tbl[i].eco, tbl[i].eovf, 100 + i);
    flush();

    // Three consecutive new inputs; each result must appear exactly one cycle later.
    drive(8'd1,  8'd2,  1'b0, 8'd3,   1'b0, 1'b0, 200);
    drive(8'd10, 8'd20, 1'b1, 8'd31,  1'b0, 1'b0, 201);
    drive(8'd200,8'd90, 1'b1, 8'd35,  1'b1, 1'b0, 202);
    flush();

    // Mid-cycle reset clears outputs without an edge.
    drive(8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0, 300);
    flush();
    #2 rst = 1'b1;
    #1;
    chk("midcycle_rst_sum", 301, {1'b0, s}, 9'd0);
    chk("midcycle_rst_co", 301, {8'd0, co}, 9'd0);
    @(negedge clk);
    rst = 1'b0;

    // Sample on the same edge as reset assertion is discarded.
    a = 8'd100; b = 8'd100; ci = 1'b1;
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("edge_rst_sum", 302, {1'b0, s}, 9'd0);
    chk("edge_rst_co", 302, {8'd0, co}, 9'd0);
    @(negedge clk);
    rst = 1'b0;

    drive(8'd100, 8'd100, 1'b1, 8'd201, 1'b0, 1'b1, 303);

    // Random sweep against the package reference.
    for (int i = 0; i < 20000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      r  = ref_add(ra, rb, rc);
      drive(ra, rb, rc, r[7:0], r[8], sign_ovf(ra, rb, r[7:0]), 1000 + i);
    end
    flush();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carry_skip_adder8.md
Name: carry_skip_adder8

Overview:
- 8-bit binary adder with carry-in, built as a carry-skip (carry-bypass) structure.
- Combinational carry-skip datapath feeds a single output register stage: sum and carry-out are registered.
- Used as a leaf arithmetic block wherever an 8-bit add with registered result is needed.

Parameters:
- BLOCK_W, 4, width of each ripple/skip block; must divide 8 evenly (legal values 1, 2, 4, 8); elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- a  input  8  addend A, unsigned
- b  input  8  addend B, unsigned
- ci  input  1  carry-in
- s  output  8  registered sum, {co,s} = a + b + ci
- co  output  1  registered carry-out

Behaviour:
- Reset is asynchronous and active-high: when rst=1, s=8'd0 and co=0 immediately, with no dependency on clk. Outputs hold these values while rst stays high.
- First capture happens on the first rising clk after rst deasserts.
- Each rising clk with rst=0 captures {co,s} <= a + b + ci. All input values are sampled at that edge.
- Latency is 1 cycle. Throughput is one add per cycle. There is no handshake and no enable.
- Arithmetic is 9-bit exact and unsigned. s is (a+b+ci) mod 256; co is bit 8.
- Maximum case: 255+255+1 gives s=255, co=1.
- Datapath structure:
  - 8/BLOCK_W blocks, each a BLOCK_W-bit ripple chain of full adders.
  - Bit propagate p_i = a_i ^ b_i; bit generate g_i = a_i & b_i.
  - Block propagate P = AND of the block's p_i.
  - Block carry-out = P ? block carry-in : ripple carry-out of the block.
  - Block 0 carry-in is ci. Each later block's carry-in is the previous block's skip-mux output.
  - co is the last block's skip-mux output.
  - Sum bits are always taken from the ripple chain, never from the skip path.
- Equivalence: the carry-skip result must be bit-identical to a + b + ci for all 2^17 input combinations. The skip path is a timing optimisation only.
- Input changes between clock edges have no effect on outputs until the next edge.
- Asserting rst between edges clears outputs at once. A sample on the same edge as rst assertion is discarded.

Optional Feature:
- Macro: CARRY_SKIP_OVF_EN.
- When defined, an extra output port ovf (1 bit) is added after co.
  - ovf is the registered two's-complement overflow: ovf = carry into bit 7 XOR carry out of bit 7.
  - It is registered with s/co, has the same latency, and resets to 0.
- When undefined, the ovf port and its logic are absent and the port list is exactly as above.

Decomposition:
- Shared package carry_skip_pkg holds:
  - ADD_W = 8 constant.
  - typedef add_word_t, logic [ADD_W-1:0].
  - Function ref_add(a, b, ci) returning the 9-bit golden sum, used by verification.
- One sub-module, carry_skip_block: BLOCK_W-bit ripple chain plus block-propagate AND and skip mux.
  - Ports: a, b, cin, s, cout, and carry-into-MSB for the overflow option.
- Top-level responsibilities: block instances via generate, carry chaining between blocks, output register.

Test Plan:
- Reset: hold rst=1 with a=127, b=127, ci=1 and toggle clk, so s=0, co=0. Assert rst mid-cycle after valid outputs, so outputs clear without a clock edge.
- Directed adds, each checked one cycle after apply:
  - 5+10+1 gives s=16, co=0.
  - 37+48+0 gives s=85, co=0.
  - 125+110+1 gives s=236, co=0.
  - 122+11+1 gives s=134, co=0.
  - 245+2+0 gives s=247, co=0.
  - 3+90+1 gives s=94, co=0.
- Carry-out cases:
  - 63+211+0 gives s=18, co=1.
  - 100+200+0 gives s=44, co=1.
  - 127+127+1 gives s=255, co=0.
  - 255+255+1 gives s=255, co=1.
- Full-skip paths:
  - a=8'hFF, b=8'h00, ci=1 gives s=0, co=1; every block propagates, so carry goes via skip muxes only.
  - a=8'hF0, b=8'h0F, ci=0 gives s=255, co=0.
- Back-to-back: change inputs every cycle for 3 consecutive cycles, so each result appears exactly 1 cycle after its inputs, with no stalls or duplicates.
- Exhaustive/random: all 131072 combinations (or ≥20k random), checked against ref_add. With CARRY_SKIP_OVF_EN, also check 127+1+0 gives ovf=1 and 128+128+0 gives s=0, co=1, ovf=1.
